// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU operations, immediate formats and ID/EX control bundle.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src_imm;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

    // funct3 -> ALU op; alt (instr[30]) selects SUB only for register ops, SRA for both
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
        case (f3)
            3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the I/S/B/U/J layout from the opcode and sign-extends to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        fmt   = FMT_R;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'h000};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_issue_stage.sv
// ID stage: decode, register-file read with WB bypass, load-use stall/bubble, flush, ID/EX register.
module decode_issue_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    input  logic             flush,
    output logic [RA_W-1:0]  rf_rs1,
    output logic [RA_W-1:0]  rf_rs2,
    input  logic [XLEN-1:0]  rf_data_rs1,
    input  logic [XLEN-1:0]  rf_data_rs2,
    input  logic             wb_we,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src_imm,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_count
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    ctrl_t           ctrl;
    ctrl_t           ex_ctrl;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            load_use;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign rd     = if_instr[7 +: RA_W];
    assign rf_rs1 = if_instr[15 +: RA_W];
    assign rf_rs2 = if_instr[20 +: RA_W];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm),
        .fmt   (fmt)
    );

    // Control decode; unknown opcodes produce a side-effect-free illegal slot
    always_comb begin
        ctrl             = '0;
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_imm = (fmt != FMT_R) && (fmt != FMT_B);
        rs1_used         = 1'b0;
        rs2_used         = 1'b0;
        case (opcode)
            OP_R: begin
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = alu_from_f3(funct3, if_instr[30], 1'b1);
            end
            OP_IMM: begin
                rs1_used       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = alu_from_f3(funct3, if_instr[30], 1'b0);
            end
            OP_LOAD: begin
                rs1_used       = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_STORE: begin
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_JALR: begin
                rs1_used       = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_PASS_B;
            end
            OP_AUIPC: ctrl.reg_write = 1'b1;
            default:  ctrl.illegal   = 1'b1;
        endcase
        ctrl.reg_write = ctrl.reg_write && (rd != '0);
    end

    // WB write-through so a same-cycle register write is seen by the decoding instruction
    assign rs1_val = (wb_we && (wb_rd != '0) && (wb_rd == rf_rs1)) ? wb_data : rf_data_rs1;
    assign rs2_val = (wb_we && (wb_rd != '0) && (wb_rd == rf_rs2)) ? wb_data : rf_data_rs2;

    assign load_use = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && if_valid &&
                      ((rs1_used && (rf_rs1 == ex_rd)) || (rs2_used && (rf_rs2 == ex_rd)));

    // A flush overrides the stall: IF discards the slot anyway
    assign id_ready = flush || !load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            stall_count <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (load_use) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            if (stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end else begin
            ex_valid   <= if_valid;
            ex_pc      <= if_pc;
            ex_imm     <= imm;
            ex_rs1_val <= rs1_val;
            ex_rs2_val <= rs2_val;
            ex_rs1     <= rf_rs1;
            ex_rs2     <= rf_rs2;
            ex_rd      <= rd;
            ex_ctrl    <= ctrl;
        end
    end

    assign ex_alu_op      = 4'(ex_ctrl.alu_op);
    assign ex_alu_src_imm = ex_ctrl.alu_src_imm;
    assign ex_mem_read    = ex_ctrl.mem_read;
    assign ex_mem_write   = ex_ctrl.mem_write;
    assign ex_reg_write   = ex_ctrl.reg_write;
    assign ex_branch      = ex_ctrl.branch;
    assign ex_jump        = ex_ctrl.jump;
    assign ex_illegal     = ex_ctrl.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: vector table through a scoreboard plus hazard/flush/reset sequences.
module tb_decode_issue_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned NVEC  = 14;

    localparam logic [31:0] LW_X6  = 32'h0000A303;
    localparam logic [31:0] ADD_X7 = 32'h002303B3;
    localparam logic [31:0] LUI_X5 = 32'h000302B7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             id_ready;
    logic             flush;
    logic [RA_W-1:0]  rf_rs1, rf_rs2;
    logic [XLEN-1:0]  rf_data_rs1, rf_data_rs2;
    logic             wb_we;
    logic [RA_W-1:0]  wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [RA_W-1:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_alu_op;
    logic             ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write;
    logic             ex_branch, ex_jump, ex_illegal;
    logic [CNT_W-1:0] stall_count;

    decode_issue_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc, rf1, rf2, wbd, imm, v1, v2;
        logic        wbe;
        logic [4:0]  wbr, rd;
        logic        src_imm, rw, ill;
        logic [3:0]  alu;
    } vec_t;

    vec_t vecs [NVEC];
    vec_t sb [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic [31:0] instr, logic [31:0] rf1, logic [31:0] rf2,
                                logic wbe, logic [4:0] wbr, logic [31:0] wbd,
                                logic [31:0] imm, logic [31:0] v1, logic [31:0] v2,
                                logic [4:0] rd, logic src_imm, logic rw, logic ill,
                                logic [3:0] alu);
        vec_t v;
        v.instr = instr; v.pc = 32'h0; v.rf1 = rf1; v.rf2 = rf2;
        v.wbe = wbe; v.wbr = wbr; v.wbd = wbd;
        v.imm = imm; v.v1 = v1; v.v2 = v2; v.rd = rd;
        v.src_imm = src_imm; v.rw = rw; v.ill = ill; v.alu = alu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        vec_t e;
        //                 instr         rf1           rf2           we  wrd  wbdata        imm           v1            v2            rd  si rw il alu
        vecs[0]  = mk(32'hFFD00293, 32'h0,        32'h0,        0, 0,  32'h0,        32'hFFFFFFFD, 32'h0,        32'h0,        5,  1, 1, 0, 0);
        vecs[1]  = mk(32'h00318233, 32'h11,       32'h22,       1, 3,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 4,  0, 1, 0, 0);
        vecs[2]  = mk(32'h00318233, 32'h11,       32'h22,       0, 3,  32'hDEADBEEF, 32'h0,        32'h11,       32'h22,       4,  0, 1, 0, 0);
        vecs[3]  = mk(32'h00000233, 32'h0,        32'h0,        1, 0,  32'hBAD0BAD0, 32'h0,        32'h0,        32'h0,        4,  0, 1, 0, 0);
        vecs[4]  = mk(32'h402083B3, 32'h55,       32'h66,       1, 2,  32'h12345678, 32'h0,        32'h55,       32'h12345678, 7,  0, 1, 0, 1);
        vecs[5]  = mk(32'h0020A423, 32'h100,      32'h200,      0, 0,  32'h0,        32'h8,        32'h100,      32'h200,      8,  1, 0, 0, 0);
        vecs[6]  = mk(32'hFE20AE23, 32'h100,      32'h200,      0, 0,  32'h0,        32'hFFFFFFFC, 32'h100,      32'h200,      28, 1, 0, 0, 0);
        vecs[7]  = mk(32'hFE208CE3, 32'h7,        32'h7,        0, 0,  32'h0,        32'hFFFFFFF8, 32'h7,        32'h7,        25, 0, 0, 0, 1);
        vecs[8]  = mk(32'h12345037, 32'h0,        32'h0,        0, 0,  32'h0,        32'h12345000, 32'h0,        32'h0,        0,  1, 0, 0, 10);
        vecs[9]  = mk(32'hABCDE4B7, 32'h0,        32'h0,        0, 0,  32'h0,        32'hABCDE000, 32'h0,        32'h0,        9,  1, 1, 0, 10);
        vecs[10] = mk(32'hFFFFF0EF, 32'h3,        32'h4,        0, 0,  32'h0,        32'hFFFFFFFE, 32'h3,        32'h4,        1,  1, 1, 0, 0);
        vecs[11] = mk(32'hFFFFFFFF, 32'h0,        32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 1, 0);
        vecs[12] = mk(32'h40225193, 32'hF0,       32'h0,        0, 0,  32'h0,        32'h00000402, 32'hF0,       32'h0,        3,  1, 1, 0, 7);
        vecs[13] = mk(32'h00001517, 32'h0,        32'h0,        0, 0,  32'h0,        32'h00001000, 32'h0,        32'h0,        10, 1, 1, 0, 0);
        for (int i = 0; i < int'(NVEC); i++) vecs[i].pc = 32'h1000 + 32'(4 * i);

        rst_n = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        rf_data_rs1 = '0; rf_data_rs2 = '0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("reset ex_valid", 32'(ex_valid), 32'd0);
        chk("reset stall_count", 32'(stall_count), 32'd0);
        chk("reset id_ready", 32'(id_ready), 32'd1);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;

        // Back-to-back vectors through the scoreboard
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].pc);
            rf_data_rs1 = vecs[i].rf1; rf_data_rs2 = vecs[i].rf2;
            wb_we = vecs[i].wbe; wb_rd = vecs[i].wbr; wb_data = vecs[i].wbd;
            sb.push_back(vecs[i]);
            tick;
            chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'd1);
            if (ex_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("v%0d ex_pc", i), ex_pc, e.pc);
                chk($sformatf("v%0d ex_imm", i), ex_imm, e.imm);
                chk($sformatf("v%0d ex_rs1_val", i), ex_rs1_val, e.v1);
                chk($sformatf("v%0d ex_rs2_val", i), ex_rs2_val, e.v2);
                chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(e.rd));
                chk($sformatf("v%0d alu_src_imm", i), 32'(ex_alu_src_imm), 32'(e.src_imm));
                chk($sformatf("v%0d reg_write", i), 32'(ex_reg_write), 32'(e.rw));
                chk($sformatf("v%0d illegal", i), 32'(ex_illegal), 32'(e.ill));
                chk($sformatf("v%0d alu_op", i), 32'(ex_alu_op), 32'(e.alu));
            end
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        wb_we = 1'b0; rf_data_rs1 = '0; rf_data_rs2 = '0;

        // Load-use: lw x6 then add x7,x6,x2 -> one bubble
        drive(1'b1, LW_X6, 32'h2000);
        tick;
        chk("lu lw mem_read", 32'(ex_mem_read), 32'd1);
        drive(1'b1, ADD_X7, 32'h2004);
        #1;
        chk("lu id_ready stall", 32'(id_ready), 32'd0);
        tick;
        chk("lu bubble ex_valid", 32'(ex_valid), 32'd0);
        chk("lu bubble mem_read", 32'(ex_mem_read), 32'd0);
        chk("lu stall_count", 32'(stall_count), 32'd1);
        chk("lu id_ready release", 32'(id_ready), 32'd1);
        tick;
        chk("lu add ex_valid", 32'(ex_valid), 32'd1);
        chk("lu add ex_rd", 32'(ex_rd), 32'd7);
        chk("lu add ex_pc", ex_pc, 32'h2004);

        // LUI does not read rs1 even when its field matches the load's rd
        drive(1'b1, LW_X6, 32'h2008);
        tick;
        drive(1'b1, LUI_X5, 32'h200C);
        #1;
        chk("lui no stall", 32'(id_ready), 32'd1);
        tick;
        chk("lui ex_valid", 32'(ex_valid), 32'd1);
        chk("lui ex_rd", 32'(ex_rd), 32'd5);
        chk("lui stall_count", 32'(stall_count), 32'd1);

        // Flush coinciding with a load-use hazard
        drive(1'b1, LW_X6, 32'h3000);
        tick;
        drive(1'b1, ADD_X7, 32'h3004);
        flush = 1'b1;
        #1;
        chk("flush id_ready", 32'(id_ready), 32'd1);
        tick;
        flush = 1'b0;
        chk("flush ex_valid", 32'(ex_valid), 32'd0);
        chk("flush stall_count", 32'(stall_count), 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick;

        // Asynchronous reset while a stall is pending
        drive(1'b1, LW_X6, 32'h4000);
        tick;
        drive(1'b1, ADD_X7, 32'h4004);
        #1;
        chk("mid-stall id_ready", 32'(id_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst ex_valid", 32'(ex_valid), 32'd0);
        chk("async rst stall_count", 32'(stall_count), 32'd0);
        chk("async rst id_ready", 32'(id_ready), 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("post rst ex_valid", 32'(ex_valid), 32'd0);
        chk("post rst stall_count", 32'(stall_count), 32'd0);

        // Stall counter saturates at all-ones
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, LW_X6, 32'h5000);
            tick;
            drive(1'b1, ADD_X7, 32'h5004);
            tick;
            chk($sformatf("sat stall_count %0d", k), 32'(stall_count), (k + 1 > 7) ? 32'd7 : 32'(k + 1));
            tick;
        end
        drive(1'b0, 32'h0, 32'h0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
